// File: rtl/eq_pkg.sv
// Shared constants for the Equalizer pot-scanning path: FSM encodings,
// A2D command field layout and the default slot-to-channel map.
package eq_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CONV  = 3'd1;
   localparam logic [2:0] ST_CWAIT = 3'd2;
   localparam logic [2:0] ST_READ  = 3'd3;
   localparam logic [2:0] ST_RWAIT = 3'd4;
   localparam logic [2:0] ST_UPD   = 3'd5;
   localparam logic [2:0] ST_GAP   = 3'd6;

   localparam int CMD_W      = 16;
   localparam int CMD_CH_LSB = 11;
   localparam int CMD_CH_W   = 3;

   // Slot order LP, B1, B2, B3, HP, VOL
   localparam logic [17:0] CH_MAP_DEF = 18'o732401;

   function automatic logic [CMD_W-1:0] a2d_cmd(input logic [CMD_CH_W-1:0] ch);
      logic [CMD_W-1:0] c;
      c = '0;
      c[CMD_CH_LSB +: CMD_CH_W] = ch;
      return c;
   endfunction

endpackage

// File: rtl/pot_filter.sv
// Shared per-sample datapath: holds the captured A2D sample, runs the IIR step
// against the slot's prior filter state and applies the hysteresis gate.
module pot_filter #(
   parameter int DATA_W    = 12,
   parameter int AVG_SHIFT = 2,
   parameter int HYST      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld,
   input  logic [DATA_W-1:0] sample_in,
   input  logic [DATA_W-1:0] filt_in,
   input  logic [DATA_W-1:0] val_in,
   input  logic              vld_in,
   output logic [DATA_W-1:0] filt_out,
   output logic              upd,
   output logic              chg,
   output logic [DATA_W-1:0] val_out
);

   localparam logic signed [DATA_W:0] HYST_V = (DATA_W+1)'(HYST);

   logic [DATA_W-1:0] sample_q, sample_d;
   logic signed [DATA_W:0] diff, step, sum, dv, adv;

   always_comb sample_d = ld ? sample_in : sample_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sample_q <= '0;
      else        sample_q <= sample_d;
   end

   // One extra bit keeps the signed step exact; the sum lands back in range.
   always_comb begin
      diff     = $signed({1'b0, sample_q}) - $signed({1'b0, filt_in});
      step     = diff >>> AVG_SHIFT;
      sum      = $signed({1'b0, filt_in}) + step;
      filt_out = vld_in ? sum[DATA_W-1:0] : sample_q;
      dv       = $signed({1'b0, filt_out}) - $signed({1'b0, val_in});
      adv      = (dv < 0) ? -dv : dv;
      upd      = !vld_in || (adv >= HYST_V);
      chg      = !vld_in || (upd && (dv != '0));
      val_out  = upd ? filt_out : val_in;
   end

endmodule

// File: rtl/pot_scanner.sv
// Round-robin pot scanner: sequences convert/read SPI transactions per slot,
// smooths each sample and publishes gated per-slot values with strobes.
module pot_scanner
   import eq_pkg::*;
#(
   parameter int                  NUM_CH    = 6,
   parameter int                  DATA_W    = 12,
   parameter logic [3*NUM_CH-1:0] CH_MAP    = (3*NUM_CH)'(CH_MAP_DEF),
   parameter int                  AVG_SHIFT = 2,
   parameter int                  HYST      = 8,
   parameter int                  GAP_CYC   = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   output logic                     snd,
   output logic [15:0]              cmd,
   input  logic                     done,
   input  logic [15:0]              resp,
   output logic [NUM_CH*DATA_W-1:0] pot_val,
   output logic [NUM_CH-1:0]        pot_vld,
   output logic [NUM_CH-1:0]        pot_chg,
   output logic                     scan_done
);

   localparam int SLOT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   logic [2:0]                          state_q, state_d;
   logic [SLOT_W-1:0]                   slot_q, slot_d;
   logic [15:0]                         cmd_q, cmd_d;
   logic [GAP_W-1:0]                    gap_q, gap_d;
   logic [NUM_CH-1:0][DATA_W-1:0]       filt_q, filt_d;
   logic [NUM_CH-1:0][DATA_W-1:0]       val_q, val_d;
   logic [NUM_CH-1:0]                   vld_q, vld_d;
   logic [NUM_CH-1:0]                   chg_q, chg_d;
   logic                                sd_q, sd_d;

   logic              ld, f_upd, f_chg;
   logic [DATA_W-1:0] f_filt, f_val;
   logic              unused_resp;

   // Upper response bits carry no A2D data.
   assign unused_resp = ^resp;

   pot_filter #(
      .DATA_W   (DATA_W),
      .AVG_SHIFT(AVG_SHIFT),
      .HYST     (HYST)
   ) u_filt (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld       (ld),
      .sample_in(resp[DATA_W-1:0]),
      .filt_in  (filt_q[slot_q]),
      .val_in   (val_q[slot_q]),
      .vld_in   (vld_q[slot_q]),
      .filt_out (f_filt),
      .upd      (f_upd),
      .chg      (f_chg),
      .val_out  (f_val)
   );

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      cmd_d   = cmd_q;
      gap_d   = gap_q;
      filt_d  = filt_q;
      val_d   = val_q;
      vld_d   = vld_q;
      chg_d   = '0;
      sd_d    = 1'b0;
      ld      = 1'b0;
      case (state_q)
         ST_IDLE:  if (en) state_d = ST_CONV;
         ST_CONV:  state_d = ST_CWAIT;
         ST_CWAIT: if (done) state_d = ST_READ;
         ST_READ:  state_d = ST_RWAIT;
         ST_RWAIT: if (done) begin
            ld      = 1'b1;
            state_d = ST_UPD;
         end
         ST_UPD: begin
            filt_d[slot_q] = f_filt;
            vld_d[slot_q]  = 1'b1;
            chg_d[slot_q]  = f_chg;
            if (f_upd) val_d[slot_q] = f_val;
            if (slot_q == SLOT_LAST) begin
               slot_d  = '0;
               sd_d    = 1'b1;
               gap_d   = '0;
               state_d = ST_GAP;
            end else begin
               slot_d  = slot_q + 1'b1;
               state_d = en ? ST_CONV : ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) state_d = en ? ST_CONV : ST_IDLE;
            else                   gap_d   = gap_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      // Command is latched on CONV entry and held through the read.
      if (state_d == ST_CONV && state_q != ST_CONV)
         cmd_d = a2d_cmd(CH_MAP[slot_d*3 +: 3]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         slot_q  <= '0;
         cmd_q   <= '0;
         gap_q   <= '0;
         filt_q  <= '0;
         val_q   <= '0;
         vld_q   <= '0;
         chg_q   <= '0;
         sd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         cmd_q   <= cmd_d;
         gap_q   <= gap_d;
         filt_q  <= filt_d;
         val_q   <= val_d;
         vld_q   <= vld_d;
         chg_q   <= chg_d;
         sd_q    <= sd_d;
      end
   end

   assign snd       = (state_q == ST_CONV) || (state_q == ST_READ);
   assign cmd       = cmd_q;
   assign pot_val   = val_q;
   assign pot_vld   = vld_q;
   assign pot_chg   = chg_q;
   assign scan_done = sd_q;

endmodule

// File: tb/tb_pot_scanner.sv
// Bench for pot_scanner: random-latency SPI responder plus an arithmetic
// reference of the smoother and hysteresis gate, checked per update and per scan.
module tb_pot_scanner;

   localparam int NUM_CH = 6, DATA_W = 12, AVG_SHIFT = 2, HYST = 8, GAP_CYC = 32;
   localparam logic [17:0] MAP = 18'o732401;
   localparam int PER = 10;

   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, done = 1'b0;
   logic [15:0] resp = '0;
   logic snd, scan_done;
   logic [15:0] cmd;
   logic [NUM_CH*DATA_W-1:0] pot_val;
   logic [NUM_CH-1:0] pot_vld, pot_chg;

   pot_scanner #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_MAP(MAP),
      .AVG_SHIFT(AVG_SHIFT), .HYST(HYST), .GAP_CYC(GAP_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .snd(snd), .cmd(cmd), .done(done),
      .resp(resp), .pot_val(pot_val), .pot_vld(pot_vld), .pot_chg(pot_chg),
      .scan_done(scan_done)
   );

   always #(PER/2) clk = ~clk;

   typedef struct {
      longint due;
      int     slot;
      int     val;
      bit     chg;
   } pend_t;

   int n_tests = 0, n_fail = 0;

   int m_filt[NUM_CH], m_val[NUM_CH], chg_cnt[NUM_CH];
   bit m_vld[NUM_CH];
   int m_slot = 0;
   int ch_val[8];
   bit jitter = 0;
   pend_t pq[$];
   pend_t p;
   logic [15:0] cmd_log[$];
   logic [15:0] last_cmd = '0;
   int exp_ch[12] = '{1, 1, 0, 0, 4, 4, 2, 2, 3, 3, 7, 7};
   int sd_cnt = 0, snd_cnt = 0, overlap = 0, wcnt = 0, conv_slot = -1, smp = 0;
   bit busy = 0, r_phase = 0, rw_flag = 0, gap_pend = 0;
   longint t_sd = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] val_of(input int s);
      return pot_val[s*DATA_W +: DATA_W];
   endfunction

   function automatic int map_ch(input int s);
      logic [17:0] m;
      m = MAP >> (3*s);
      return int'(m[2:0]);
   endfunction

   // Reference: first sample loads, later samples move 1/2^AVG_SHIFT of the
   // way (floor), and the reported value follows only on a big enough move.
   task automatic model_upd(input int s);
      int sl, d;
      bit c;
      sl = m_slot;
      if (!m_vld[sl]) begin
         m_filt[sl] = s;
         m_val[sl]  = s;
         c = 1'b1;
      end else begin
         m_filt[sl] = m_filt[sl] + ((s - m_filt[sl]) >>> AVG_SHIFT);
         d = m_filt[sl] - m_val[sl];
         if (d < 0) d = -d;
         c = 1'b0;
         if (d >= HYST) begin
            c = (d != 0);
            m_val[sl] = m_filt[sl];
         end
      end
      m_vld[sl] = 1'b1;
      pq.push_back('{due: longint'($time) + 2*PER, slot: sl, val: m_val[sl], chg: c});
      m_slot = (m_slot + 1) % NUM_CH;
   endtask

   // Monitor, scoreboard and SPI responder share one process for ordering.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         done = 1'b0; resp = '0; busy = 0; r_phase = 0; rw_flag = 0; gap_pend = 0;
         m_slot = 0; conv_slot = -1;
         pq.delete();
         cmd_log.delete();
         for (int i = 0; i < NUM_CH; i++) begin
            m_filt[i] = 0; m_val[i] = 0; m_vld[i] = 0; chg_cnt[i] = 0;
         end
      end else begin
         while (pq.size() > 0 && pq[0].due <= longint'($time)) begin
            p = pq.pop_front();
            chk("upd_val", 32'(val_of(p.slot)), 32'(p.val));
            chk("upd_chg", 32'(pot_chg[p.slot]), 32'(p.chg));
         end
         for (int i = 0; i < NUM_CH; i++) if (pot_chg[i]) chg_cnt[i]++;
         if (scan_done) begin
            sd_cnt++;
            t_sd = longint'($time);
            gap_pend = en;
            chk("sd_slot", 32'(m_slot), 0);
            for (int i = 0; i < NUM_CH; i++) begin
               chk("scan_val", 32'(val_of(i)), 32'(m_val[i]));
               chk("scan_vld", 32'(pot_vld[i]), 32'(m_vld[i]));
            end
         end
         if (done) begin
            done = 1'b0; busy = 0; rw_flag = 0; r_phase = ~r_phase;
         end
         if (snd) begin
            if (busy) overlap++;
            else begin
               busy = 1; snd_cnt++;
               wcnt = int'($urandom_range(1, 3));
               cmd_log.push_back(cmd);
               if (!r_phase) begin
                  chk("cmd", 32'(cmd), {16'h0, 2'b00, 3'(map_ch(m_slot)), 11'h0});
                  conv_slot = m_slot;
                  last_cmd = cmd;
                  if (gap_pend) begin
                     chk("gap_len", 32'((longint'($time) - t_sd) / PER), GAP_CYC);
                     gap_pend = 0;
                  end
               end else begin
                  chk("cmd_hold", 32'(cmd), 32'(last_cmd));
                  rw_flag = 1;
               end
            end
         end else if (busy) begin
            wcnt--;
            if (wcnt == 0) begin
               done = 1'b1;
               if (r_phase) begin
                  if (jitter && cmd[13:11] == 3'd2) smp = 32'h400 + int'($urandom_range(0, 6)) - 3;
                  else smp = ch_val[cmd[13:11]];
                  resp = 16'(smp);
                  model_upd(smp);
               end else resp = 16'($urandom);
            end
         end
      end
   end

   task automatic wait_sd(input string tag);
      int tgt;
      tgt = sd_cnt + 1;
      for (int i = 0; i < 600 && sd_cnt < tgt; i++) @(posedge clk);
      chk({"sd_", tag}, 32'(sd_cnt), 32'(tgt));
   endtask

   task automatic wait_snd(input string tag);
      int k;
      k = 0;
      while (!snd && k < 400) begin @(posedge clk); #1; k++; end
      chk({"snd_", tag}, 32'(snd), 1);
   endtask

   initial begin
      int k, base;
      for (int i = 0; i < 8; i++) ch_val[i] = 0;
      #(3*PER + 1);
      chk("rst_snd", 32'(snd), 0);
      chk("rst_cmd", 32'(cmd), 0);
      chk("rst_val", 32'(|pot_val), 0);
      chk("rst_vld", 32'(pot_vld), 0);
      chk("rst_chg", 32'(pot_chg), 0);
      chk("rst_sd", 32'(scan_done), 0);

      // First scan: load, scan order, valid and single change strobe per slot
      for (int i = 0; i < 8; i++) ch_val[i] = 'h800;
      @(posedge clk); #2 rst_n = 1'b1; en = 1'b1;
      wait_sd("first");
      chk("vld_all", 32'(pot_vld), 32'h3F);
      chk("log_n", 32'(cmd_log.size()), 12);
      for (int i = 0; i < 12 && i < cmd_log.size(); i++) chk("order", 32'(cmd_log[i][13:11]), 32'(exp_ch[i]));
      for (int i = 0; i < NUM_CH; i++) begin
         chk("first_val", 32'(val_of(i)), 32'h800);
         chk("first_chg_n", 32'(chg_cnt[i]), 1);
      end

      // Step slot 0 (channel 1) and follow the smoother
      ch_val[1] = 'h840;
      wait_sd("iir1"); chk("iir_810", 32'(val_of(0)), 32'h810);
      wait_sd("iir2"); chk("iir_81c", 32'(val_of(0)), 32'h81C);
      wait_sd("iir3"); chk("iir_825", 32'(val_of(0)), 32'h825);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 8; i++) ch_val[i] = int'($urandom_range(0, 4095));
         wait_sd("rand");
      end

      // Reset while a read is outstanding
      k = 0;
      while (!rw_flag && k < 400) begin @(posedge clk); k++; end
      chk("rwait_seen", 32'(rw_flag), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_snd", 32'(snd), 0);
      chk("mid_rst_cmd", 32'(cmd), 0);
      chk("mid_rst_val", 32'(|pot_val), 0);
      chk("mid_rst_vld", 32'(pot_vld), 0);
      chk("mid_rst_chg", 32'(pot_chg), 0);
      chk("mid_rst_sd", 32'(scan_done), 0);
      ch_val[2] = 'h400;
      ch_val[0] = 4094;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b1;
      wait_snd("after_rst");
      chk("rst_first_cmd", 32'(cmd), 32'h0800);
      wait_sd("post_rst");
      chk("jit_base", 32'(val_of(3)), 32'h400);
      chk("fs_base", 32'(val_of(1)), 4094);

      // Jitter on slot 3 and full-scale truncation on slot 1
      jitter = 1;
      ch_val[0] = 4095;
      repeat (4) wait_sd("jit");
      chk("jit_val", 32'(val_of(3)), 32'h400);
      chk("jit_chg_n", 32'(chg_cnt[3]), 1);
      chk("fs_val", 32'(val_of(1)), 4094);
      chk("fs_chg_n", 32'(chg_cnt[1]), 1);
      jitter = 0;

      // Drop enable while slot 2 waits for its conversion
      ch_val[4] = 'h123;
      k = 0;
      while (conv_slot != 2 && k < 400) begin @(posedge clk); #1; k++; end
      chk("cwait2_seen", 32'(conv_slot), 2);
      base = snd_cnt;
      en = 1'b0;
      repeat (100) @(posedge clk);
      chk("en_drop_snd", 32'(snd_cnt - base), 1);
      chk("en_drop_slot", 32'(m_slot), 3);
      chk("en_drop_val2", 32'(val_of(2)), 32'(m_val[2]));
      #1 en = 1'b1;
      wait_snd("resume");
      chk("resume_cmd", 32'(cmd), 32'h1000);
      wait_sd("resume");

      chk("snd_overlap", 32'(overlap), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
